aqfp_pipo_sequencer: RTL
========================

// Module: aqfp_pipo_sequencer
// PURPOSE
//  CMOS-side launch/capture engine for an 8-phase AQFP netlist: takes input vectors over
//  valid/ready, launches them onto the netlist PI bus on the phase-1 boundary, and captures
//  PO values LAT_PHASES clocks later. Captured vectors go out over valid/ready with backpressure.
//  Sits between the test/stream logic and the emulated netlist (PI_AQFP...PO_AQFP).
//  One launch per phase rotation.
// PARAMETERS
//  N_PI        5   PI bus width (netlist primary inputs)
//  N_PO        2   PO bus width (netlist primary outputs)
//  LAT_PHASES  9   phases from launch to valid PO (PI@clk_1 -> PO@clk_2 next rotation); >=1
//  OUT_DEPTH   4   output FIFO depth (power of 2, >=2); also max vectors in flight + queued
// PORTS
//  clk        in   1          single clock; one period = one AQFP phase
//  rst_n      in   1          synchronous reset, active-low
//  in_valid   in   1          input vector offered
//  in_ready   out  1          input holding register empty
//  in_data    in   N_PI       input vector
//  phase_oh   out  8          one-hot phase; bit k high while phase_cnt==k (bit0 = clk_1)
//  pi_data    out  N_PI       vector driven to netlist PIs, stable for a whole rotation
//  po_data    in   N_PO       netlist PO outputs
//  out_valid  out  1          captured vector available (FIFO non-empty)
//  out_ready  in   1          downstream accepts
//  out_data   out  N_PO       FIFO head
//  in_flight  out  4          vectors launched, not yet captured
// BEHAVIOUR
//  Reset (rst_n=0 at edge): phase_cnt=0, phase_oh=8'h01, pi_data=0, hold empty, in_ready=0
//   during reset then 1, delay line cleared, FIFO empty, out_valid=0, in_flight=0.
//  Phase counter: 3-bit, increments every clk, wraps 7->0 ("launch edge" = edge into cnt 0).
//  Input: in_valid&&in_ready loads hold register (1 entry); in_ready = !hold_valid.
//   Accept and launch of the same entry in one cycle are permitted.
//  Launch, at launch edge only: if hold_valid && credit_ok -> pi_data<=hold, hold_valid<=0,
//   delay-line bit 0 <=1. Otherwise bubble: pi_data<=0, bit 0 <=0, and hold is kept.
//  credit_ok = (in_flight + fifo_count) < OUT_DEPTH, using pre-edge values (pops this cycle
//   ignored; conservative). The FIFO therefore never overflows and po_data is never dropped.
//  Delay line: LAT_PHASES-bit shift register, shifts every clk. Capture when the tap is set:
//   po_data is sampled into the FIFO at edge launch+LAT_PHASES. out_valid is high from the
//   next cycle; minimum in_data->out_data latency = LAT_PHASES+1 cycles after launch edge.
//  in_flight: +1 on launch, -1 on capture; simultaneous launch+capture leaves it unchanged.
//  FIFO: push on capture, pop on out_valid&&out_ready; push and pop in the same cycle are both
//   performed and count is unchanged; push into empty shows data the next cycle (no bypass).
//  out_data holds while out_valid && !out_ready. out_data when empty = last value (don't care).
//  LAT_PHASES>8: several vectors in flight (max ceil(LAT_PHASES/8)); ordering strictly FIFO.
//  Reset mid-operation: in-flight and queued vectors are discarded, no partial outputs.
// STRUCTURE
//  aqfp_pkg: N_PHASES=8, typedef logic [2:0] phase_t, function phase_onehot(phase_t).
//  Sub-module aqfp_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, sync active-low reset);
//   reusable for the PI-side stimulus queue.
//  Top: phase counter, hold register, launch logic, delay line, credit/in_flight counters.
// TESTING
//  Reset: hold rst_n=0 for 3 clks with in_valid=1 -> phase_oh=01, pi_data=0, out_valid=0,
//   in_flight=0; first launch edge 8 clks after release.
//  Single vector: in_data=5'b10110, po_data model = c17(pi) delayed 9 clks ->
//   out_data=c17(10110), out_valid 10 clks after launch edge.
//  Streaming: 16 back-to-back vectors, out_ready=1 -> one launch per 8 clks, outputs in order,
//   no bubbles after fill.
//  Backpressure: out_ready=0 -> exactly 4 vectors captured, launches stop (bubbles,
//   pi_data=0); release -> remaining vectors drain in order with none lost.
//  LAT_PHASES=17: in_flight reaches 3; captures match launch order.
//  Mid-run reset with 2 in flight and 1 queued -> nothing emitted after reset; clean restart.

Source files
------------

// File: rtl/aqfp_pipo_sequencer_pkg.sv
// Shared phase types and helpers for the AQFP launch/capture sequencer.
package aqfp_pipo_sequencer_pkg;

    localparam int N_PHASES = 8;

    typedef logic [2:0] phase_t;

    // The launch edge is the edge that wraps the counter back to phase 0.
    localparam phase_t LAUNCH_PHASE = 3'd7;

    function automatic logic [N_PHASES-1:0] phase_onehot(input phase_t ph);
        logic [N_PHASES-1:0] oh;
        oh     = 8'h00;
        oh[ph] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/aqfp_pipo_sequencer_if.sv
// Input and output valid/ready streams of the sequencer.
interface aqfp_pipo_sequencer_if #(
    parameter int N_PI = 5,
    parameter int N_PO = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [N_PI-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N_PO-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aqfp_pipo_sequencer_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, no write-to-read bypass.
module aqfp_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == {CW{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/aqfp_pipo_sequencer.sv
// Launches input vectors onto the AQFP PI bus once per phase rotation and
// captures PO values LAT_PHASES clocks later into a credit-protected FIFO.
module aqfp_pipo_sequencer
    import aqfp_pipo_sequencer_pkg::*;
#(
    parameter int N_PI       = 5,
    parameter int N_PO       = 2,
    parameter int LAT_PHASES = 9,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aqfp_pipo_sequencer_if.slave  bus,
    output logic [N_PHASES-1:0]   phase_oh,
    output logic [N_PI-1:0]       pi_data,
    input  logic [N_PO-1:0]       po_data,
    output logic [3:0]            in_flight
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    phase_t                phase_q, phase_d;
    logic [N_PHASES-1:0]   phase_oh_q, phase_oh_d;
    logic [N_PI-1:0]       hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [N_PI-1:0]       pi_data_q, pi_data_d;
    logic [LAT_PHASES-1:0] dl_q, dl_d;
    logic [3:0]            in_flight_q, in_flight_d;

    logic                  accept_s, launch_s, capture_s, credit_ok_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;
    logic [N_PO-1:0]       fifo_data_s;

    assign accept_s    = bus.in_valid && in_ready_q;
    assign capture_s   = dl_q[LAT_PHASES-1];
    // Pre-edge occupancy only: a pop in this cycle does not free a credit yet.
    assign credit_ok_s = (int'(in_flight_q) + int'(fifo_count_s)) < OUT_DEPTH;
    assign launch_s    = (phase_q == LAUNCH_PHASE) && (hold_valid_q || accept_s) && credit_ok_s;

    // Next-state for phase, hold register, PI bus, delay line and credits.
    always_comb begin
        phase_d      = phase_q + 3'd1;
        phase_oh_d   = phase_onehot(phase_d);
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pi_data_d    = pi_data_q;
        if (launch_s) begin
            hold_valid_d = 1'b0;
        end else if (accept_s) begin
            hold_d       = bus.in_data;
            hold_valid_d = 1'b1;
        end else begin
            hold_valid_d = hold_valid_q;
        end
        // An entry arriving on the launch edge itself goes straight to the bus.
        if (phase_q == LAUNCH_PHASE) begin
            pi_data_d = launch_s ? (hold_valid_q ? hold_q : bus.in_data) : {N_PI{1'b0}};
        end else begin
            pi_data_d = pi_data_q;
        end
        in_ready_d = !hold_valid_d;
        dl_d       = (dl_q << 1) | LAT_PHASES'(launch_s);
        case ({launch_s, capture_s})
            2'b10:   in_flight_d = in_flight_q + 4'd1;
            2'b01:   in_flight_d = in_flight_q - 4'd1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q      <= 3'd0;
            phase_oh_q   <= 8'h01;
            hold_q       <= {N_PI{1'b0}};
            hold_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            pi_data_q    <= {N_PI{1'b0}};
            dl_q         <= {LAT_PHASES{1'b0}};
            in_flight_q  <= 4'd0;
        end else begin
            phase_q      <= phase_d;
            phase_oh_q   <= phase_oh_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            in_ready_q   <= in_ready_d;
            pi_data_q    <= pi_data_d;
            dl_q         <= dl_d;
            in_flight_q  <= in_flight_d;
        end
    end

    aqfp_sync_fifo #(
        .WIDTH (N_PO),
        .DEPTH (OUT_DEPTH),
        .CW    (CW)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (capture_s && !fifo_full_s),
        .push_data_i (po_data),
        .pop_i       (bus.out_valid && bus.out_ready),
        .pop_data_o  (fifo_data_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.out_data  = fifo_data_s;
    assign phase_oh      = phase_oh_q;
    assign pi_data       = pi_data_q;
    assign in_flight     = in_flight_q;

endmodule
